// File: rtl/stolen_cdc_array_filter.sv
// Multi-channel synchroniser for slow asynchronous status lines: a per-channel
// flop chain, a stability filter, and registered rise/fall/change pulses.
module stolen_cdc_array_filter #(
   parameter int               WIDTH         = 8,
   parameter int               DEST_SYNC_FF  = 4,
   parameter int               FILTER_CYCLES = 4,
   parameter logic [WIDTH-1:0] INIT_VAL      = '0
) (
   input  logic             dest_clk,
   input  logic             dest_rst,
   input  logic [WIDTH-1:0] src_in,
   output logic [WIDTH-1:0] dest_out,
   output logic [WIDTH-1:0] dest_rise,
   output logic [WIDTH-1:0] dest_fall,
   output logic             dest_change
);

   localparam int CNT_W = $clog2(FILTER_CYCLES + 1);
   typedef logic [CNT_W-1:0] cnt_t;

   // Tools must keep this chain intact and place the stages close together.
   (* DONT_TOUCH = "TRUE", STOLEN_CDC = "ARRAY_FILTER", ASYNC_REG = "TRUE" *)
   logic [WIDTH-1:0] syncstages_ff [DEST_SYNC_FF];

   logic [WIDTH-1:0]            sync_q;
   logic [WIDTH-1:0][CNT_W-1:0] cnt_q, cnt_d;
   logic [WIDTH-1:0]            dest_out_q, dest_out_d;
   logic [WIDTH-1:0]            dest_rise_q, dest_rise_d;
   logic [WIDTH-1:0]            dest_fall_q, dest_fall_d;
   logic                        dest_change_q, dest_change_d;

   // NOTE: sequential state uses non-blocking assignments so every stage
   // samples its predecessor's pre-edge value.
   always_ff @(posedge dest_clk) begin
      if (dest_rst) begin
         for (int k = 0; k < DEST_SYNC_FF; k++) syncstages_ff[k] <= INIT_VAL;
      end else begin
         syncstages_ff[0] <= src_in;
         for (int k = 1; k < DEST_SYNC_FF; k++) syncstages_ff[k] <= syncstages_ff[k-1];
      end
   end

   assign sync_q = syncstages_ff[DEST_SYNC_FF-1];

   // NOTE: every always_comb output gets a default first, so no latch is inferred.
   always_comb begin
      dest_out_d = dest_out_q;
      cnt_d      = cnt_q;
      for (int i = 0; i < WIDTH; i++) begin
         if (sync_q[i] == dest_out_q[i]) begin
            cnt_d[i] = '0;
         end else if (cnt_q[i] == cnt_t'(FILTER_CYCLES - 1)) begin
            dest_out_d[i] = sync_q[i];
            cnt_d[i]      = '0;
         end else begin
            cnt_d[i] = cnt_q[i] + cnt_t'(1);
         end
      end
      dest_rise_d   = dest_out_d & ~dest_out_q;
      dest_fall_d   = ~dest_out_d & dest_out_q;
      dest_change_d = |(dest_rise_d | dest_fall_d);
   end

   always_ff @(posedge dest_clk) begin
      if (dest_rst) begin
         cnt_q         <= '0;
         dest_out_q    <= INIT_VAL;
         dest_rise_q   <= '0;
         dest_fall_q   <= '0;
         dest_change_q <= 1'b0;
      end else begin
         cnt_q         <= cnt_d;
         dest_out_q    <= dest_out_d;
         dest_rise_q   <= dest_rise_d;
         dest_fall_q   <= dest_fall_d;
         dest_change_q <= dest_change_d;
      end
   end

   assign dest_out    = dest_out_q;
   assign dest_rise   = dest_rise_q;
   assign dest_fall   = dest_fall_q;
   assign dest_change = dest_change_q;

endmodule

// File: tb/tb_stolen_cdc_array_filter.sv
// Self-checking bench: directed scenarios plus random stimulus, compared each
// cycle against a history-based model of the synchroniser and filter.
module tb_stolen_cdc_array_filter;

   localparam int          W    = 4;
   localparam int          DSF  = 3;
   localparam int          FC   = 4;
   localparam logic [W-1:0] INIT = 4'b0000;

   logic         dest_clk = 1'b0;
   logic         dest_rst;
   logic [W-1:0] src_in;
   logic [W-1:0] dest_out, dest_rise, dest_fall;
   logic         dest_change;

   int n_checks = 0;
   int n_fail   = 0;
   int pulse_cnt = 0;

   // Model: a delay line for the synchroniser, and the last FC synchronised
   // samples; a channel flips once all of them disagree with its output.
   logic [W-1:0] m_stg [DSF];
   logic [W-1:0] m_hist [$];
   logic [W-1:0] m_out, m_rise, m_fall;
   logic         m_chg;

   stolen_cdc_array_filter #(
      .WIDTH(W), .DEST_SYNC_FF(DSF), .FILTER_CYCLES(FC), .INIT_VAL(INIT)
   ) dut (
      .dest_clk   (dest_clk),
      .dest_rst   (dest_rst),
      .src_in     (src_in),
      .dest_out   (dest_out),
      .dest_rise  (dest_rise),
      .dest_fall  (dest_fall),
      .dest_change(dest_change)
   );

   always #5 dest_clk = ~dest_clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic step(input logic [W-1:0] s, input logic r);
      logic [W-1:0] pre, nxt;
      bit           all_diff;
      @(negedge dest_clk);
      src_in   = s;
      dest_rst = r;
      @(posedge dest_clk);
      if (r) begin
         for (int k = 0; k < DSF; k++) m_stg[k] = INIT;
         m_hist.delete();
         m_out  = INIT;
         m_rise = '0;
         m_fall = '0;
         m_chg  = 1'b0;
      end else begin
         pre = m_stg[DSF-1];
         m_hist.push_back(pre);
         if (m_hist.size() > FC) void'(m_hist.pop_front());
         nxt = m_out;
         if (m_hist.size() == FC) begin
            for (int i = 0; i < W; i++) begin
               all_diff = 1'b1;
               for (int j = 0; j < FC; j++)
                  if (m_hist[j][i] == m_out[i]) all_diff = 1'b0;
               if (all_diff) nxt[i] = ~m_out[i];
            end
         end
         m_rise = nxt & ~m_out;
         m_fall = ~nxt & m_out;
         m_chg  = |(m_rise | m_fall);
         m_out  = nxt;
         for (int k = DSF - 1; k > 0; k--) m_stg[k] = m_stg[k-1];
         m_stg[0] = s;
      end
      #1;
      check("model_out",    32'(dest_out),    32'(m_out));
      check("model_rise",   32'(dest_rise),   32'(m_rise));
      check("model_fall",   32'(dest_fall),   32'(m_fall));
      check("model_change", 32'(dest_change), 32'(m_chg));
      pulse_cnt += $countones(dest_rise | dest_fall) + int'(dest_change);
   endtask

   task automatic run(input logic [W-1:0] s, input int n);
      for (int k = 0; k < n; k++) step(s, 1'b0);
   endtask

   initial begin
      int base, rises2, falls2;
      logic [W-1:0] cur;
      int hold;
      logic [31:0] seq2;
      src_in   = '0;
      dest_rst = 1'b1;

      // Reset with inputs active, then the first capture lands on the 7th edge.
      for (int k = 0; k < 3; k++) begin
         step(4'b1010, 1'b1);
         check("rst_out",   32'(dest_out), 32'(INIT));
         check("rst_pulse", 32'({dest_rise, dest_fall, dest_change}), 32'(0));
      end
      for (int k = 1; k <= 7; k++) begin
         step(4'b1010, 1'b0);
         if (k == 6) check("rel_out_e6", 32'(dest_out), 32'(4'b0000));
      end
      check("rel_out_e7",  32'(dest_out),    32'(4'b1010));
      check("rel_rise_e7", 32'(dest_rise),   32'(4'b1010));
      check("rel_fall_e7", 32'(dest_fall),   32'(4'b0000));
      check("rel_chg_e7",  32'(dest_change), 32'(1));
      step(4'b1010, 1'b0);
      check("rel_rise_e8", 32'(dest_rise),   32'(0));
      check("rel_chg_e8",  32'(dest_change), 32'(0));

      // Clean step on channel 0, rise then fall.
      for (int k = 1; k <= 7; k++) begin
         step(4'b1011, 1'b0);
         if (k == 6) check("step_out_e6", 32'(dest_out[0]), 32'(0));
      end
      check("step_rise", 32'(dest_rise),   32'(4'b0001));
      check("step_chg",  32'(dest_change), 32'(1));
      for (int k = 1; k <= 7; k++) begin
         step(4'b1010, 1'b0);
         if (k == 6) check("fall_out_e6", 32'(dest_out[0]), 32'(1));
      end
      check("step_fall", 32'(dest_fall), 32'(4'b0001));
      check("step_out",  32'(dest_out),  32'(4'b1010));
      run(4'b1010, 2);

      // Glitch on channel 2 shorter than the window is rejected.
      base = pulse_cnt;
      run(4'b1110, 3);
      run(4'b1010, 12);
      check("glitch_out",    32'(dest_out),  32'(4'b1010));
      check("glitch_pulses", 32'(pulse_cnt), 32'(base));

      // Four-cycle pulse accepted, then a bounce back to low: one rise, one fall.
      rises2 = 0;
      falls2 = 0;
      seq2 = 32'b0000_0000_0000_0000_0000_0000_0000_1111;
      seq2 = seq2 | (32'b1 << 5);
      for (int k = 0; k < 20; k++) begin
         step({1'b1, seq2[k], 2'b10}, 1'b0);
         rises2 += int'(dest_rise[2]);
         falls2 += int'(dest_fall[2]);
      end
      check("bounce_rises", 32'(rises2), 32'(1));
      check("bounce_falls", 32'(falls2), 32'(1));
      check("bounce_out",   32'(dest_out), 32'(4'b1010));

      // Simultaneous rise and fall on different channels.
      run(4'b0010, 10);
      check("sim_pre_out", 32'(dest_out), 32'(4'b0010));
      base = pulse_cnt;
      for (int k = 1; k <= 7; k++) step(4'b0001, 1'b0);
      check("sim_rise", 32'(dest_rise),   32'(4'b0001));
      check("sim_fall", 32'(dest_fall),   32'(4'b0010));
      check("sim_chg",  32'(dest_change), 32'(1));
      step(4'b0001, 1'b0);
      check("sim_chg_once", 32'(pulse_cnt - base), 32'(3));

      // Reset while channel 3 has a pending count of two.
      run(4'b1001, 5);
      step(4'b1001, 1'b1);
      check("midrst_out",   32'(dest_out), 32'(INIT));
      check("midrst_pulse", 32'({dest_rise, dest_fall, dest_change}), 32'(0));
      for (int k = 1; k <= 7; k++) begin
         step(4'b1001, 1'b0);
         if (k == 6) check("midrst_out_e6", 32'(dest_out[3]), 32'(0));
      end
      check("midrst_out_e7",  32'(dest_out[3]),  32'(1));
      check("midrst_rise_e7", 32'(dest_rise[3]), 32'(1));

      // Channel 1 toggling every two cycles never gets through.
      run(4'b0000, 10);
      base = pulse_cnt;
      for (int k = 0; k < 50; k++) run((k % 2 == 0) ? 4'b0010 : 4'b0000, 2);
      run(4'b0000, 10);
      check("toggle_out",    32'(dest_out),  32'(0));
      check("toggle_pulses", 32'(pulse_cnt), 32'(base));

      // Random hold lengths around the filter window, with occasional reset.
      for (int t = 0; t < 150; t++) begin
         cur  = W'($urandom);
         hold = int'($urandom_range(1, 8));
         if ($urandom_range(0, 40) == 0) step(cur, 1'b1);
         run(cur, hold);
      end
      run(4'b0101, 12);
      check("rand_final_out", 32'(dest_out), 32'(4'b0101));

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
